icb_slv_test: RTL and testbench
===============================

# icb_slv_test

Memory-mapped ICB test slave attached to the SoC's external MVU ICB port (`mvu_icb_*` of `e203_soc_top`). It gives firmware a small register window for bus bring-up: scratch registers with byte-masked writes, a constant ID register and a write counter. It is a single-outstanding slave with registered responses and full ICB handshake compliance.

## Interface
Parameters:
- `ID_VALUE`, default 32'h4D56_5530: constant returned by the ID register.
- `WIN_BITS`, default 12: decoded offset width. `addr[WIN_BITS-1:5]` must be zero, otherwise the access errors.

Ports (clock and reset first):
- `hfclk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `bus_rst_n`  in  1  soft reset, synchronous, active-low; same effect as `rst_n`. Tied 1 in system use.
- `i_icb_cmd_valid`  in  1  command valid.
- `i_icb_cmd_ready`  out  1  command ready.
- `i_icb_cmd_addr`  in  32  byte address; only `[WIN_BITS-1:0]` is decoded.
- `i_icb_cmd_read`  in  1  1 = read, 0 = write.
- `i_icb_cmd_wdata`  in  32  write data.
- `i_icb_cmd_wmask`  in  4  byte enables; bit n covers byte n.
- `i_icb_rsp_valid`  out  1  response valid.
- `i_icb_rsp_ready`  in  1  response ready.
- `i_icb_rsp_rdata`  out  32  read data.
- `i_icb_rsp_err`  out  1  error response.

## Operation
Register map (word offset = `addr[4:2]`):
- 0x00–0x14: SCR0–SCR5. Read/write, reset 0.
- 0x18: ID. Read-only, returns `ID_VALUE`.
- 0x1C: WCNT. Read-only, reset 0. Counts non-error write commands accepted; wraps 0xFFFF_FFFF→0.

Address bits:
- `addr[1:0]` are ignored.
- Upper offset bits `[WIN_BITS-1:5]` nonzero → out-of-window access.

Accepted command = `cmd_valid & cmd_ready` at a rising edge.

Write:
- SCRn bytes with `wmask` set take `wdata` bytes at the accept edge.
- `wmask` = 0 still counts as a write and increments WCNT.
- Writes to ID or WCNT are ignored, `err`=0, and still increment WCNT.

Read:
- `rdata` is captured at the accept edge from the current register values.
- Read responses return `err`=0.

Out-of-window access:
- `err`=1, `rdata`=0.
- The write is dropped and WCNT does not change.

Write responses return `rdata`=0.

## Timing
- `cmd_ready = ~rsp_valid | rsp_ready` (combinational). This allows back-to-back transactions at one per cycle.
- Response latency: `rsp_valid` rises 1 cycle after the accept edge.
- `rsp_valid`, `rdata` and `err` are held stable until `rsp_valid & rsp_ready`.
- At a cycle with both a response handshake and a new accept, `rsp_valid` stays 1 and the new response is loaded.
- A read accepted the cycle after a write to the same register returns the new value.
- Reset values: `rsp_valid`=0, `rdata`=0, `err`=0, all SCR=0, WCNT=0. `cmd_ready`=1 during and after reset.
- Reset mid-transaction drops any pending response; no response is issued for it.
- `bus_rst_n`=0 has priority over any accept in the same cycle.

## Structure
- Shared package `icb_slv_test_pkg`:
  - register offset constants `SCR0_OFS`…`WCNT_OFS`
  - `ID_VALUE` default
  - number of scratch registers (6)
- Sub-module `icb_slv_test_regfile`: SCR array with byte-mask write, ID mux and WCNT. The top holds the handshake and response registers.
- Expected size 150–250 lines of RTL.

## Test plan
- **Reset:** `rst_n`=0 then 1 → `cmd_ready`=1, `rsp_valid`=0. Read 0x00 → 0, read 0x18 → 0x4D565530, read 0x1C → 0, all with `err`=0.
- **Byte mask:**
  - write 0x04 = 0xDEADBEEF with `wmask`=4'hF → read 0x04 = 0xDEADBEEF
  - then write 0x11223344 with `wmask`=4'b0101 → read 0x04 = 0xDE22BE44
  - WCNT = 2
- **Back-to-back, no response stall:** with `rsp_ready`=1, issue write 0x08 = 0x55 then read 0x08 on consecutive cycles. Expect two responses on consecutive cycles, the second with `rdata`=0x55.
- **Response backpressure:** read 0x18 with `rsp_ready`=0 for 5 cycles → `cmd_ready`=0, `rsp_valid`=1, `rdata` stable at 0x4D565530 throughout. Release `rsp_ready` → handshake completes and `cmd_ready`=1.
- **Errors / read-only:**
  - write 0x40 = 0xFF → `err`=1, WCNT unchanged
  - read 0x100 → `err`=1, `rdata`=0
  - write 0x18 = 0 → `err`=0, ID unchanged, WCNT +1
- **Reset mid-operation:** assert `rst_n`=0 while a response is pending → `rsp_valid` drops immediately and SCR0–SCR5 read 0 afterward. Repeat with `bus_rst_n`=0 for one cycle → same result at the next edge.

Source files
------------

// File: rtl/icb_slv_test_pkg.sv
// Shared constants for the ICB bring-up test slave.
package icb_slv_test_pkg;

    localparam logic [31:0] ID_VALUE_DEF = 32'h4D56_5530;
    localparam int          NUM_SCR      = 6;

    localparam logic [4:0] SCR0_OFS = 5'h00;
    localparam logic [4:0] SCR1_OFS = 5'h04;
    localparam logic [4:0] SCR2_OFS = 5'h08;
    localparam logic [4:0] SCR3_OFS = 5'h0C;
    localparam logic [4:0] SCR4_OFS = 5'h10;
    localparam logic [4:0] SCR5_OFS = 5'h14;
    localparam logic [4:0] ID_OFS   = 5'h18;
    localparam logic [4:0] WCNT_OFS = 5'h1C;

    // Word index of a byte offset inside the 32-byte register window.
    function automatic logic [2:0] word_idx(input logic [4:0] ofs);
        return ofs[4:2];
    endfunction

endpackage

// File: rtl/icb_slv_test_regfile.sv
// Register array for the test slave: six byte-maskable scratch words,
// a constant ID word and a counter of accepted in-window writes.
module icb_slv_test_regfile
    import icb_slv_test_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEF
) (
    input  logic        hfclk,
    input  logic        rst_n,
    input  logic        bus_rst_n,
    input  logic        we_i,
    input  logic [2:0]  idx_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wmask_i,
    output logic [31:0] rdata_o
);

    logic [31:0] scr_q [NUM_SCR];
    logic [31:0] scr_d [NUM_SCR];
    logic [31:0] wcnt_q;
    logic [31:0] wcnt_d;

    // Next-state: byte-masked scratch update; every in-window write counts,
    // including writes to the read-only words and writes with an empty mask.
    always_comb begin
        scr_d  = scr_q;
        wcnt_d = wcnt_q;
        if (we_i) begin
            wcnt_d = wcnt_q + 32'd1;
            for (int i = 0; i < NUM_SCR; i++) begin
                if (idx_i == 3'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wmask_i[b]) begin
                            scr_d[i][8*b +: 8] = wdata_i[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Register state; the soft reset acts like the hard one at the clock edge.
    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SCR; i++) scr_q[i] <= '0;
            wcnt_q <= '0;
        end else if (!bus_rst_n) begin
            for (int i = 0; i < NUM_SCR; i++) scr_q[i] <= '0;
            wcnt_q <= '0;
        end else begin
            scr_q  <= scr_d;
            wcnt_q <= wcnt_d;
        end
    end

    // Read mux over the current register values.
    always_comb begin
        rdata_o = '0;
        if (idx_i == word_idx(ID_OFS)) begin
            rdata_o = ID_VALUE;
        end else if (idx_i == word_idx(WCNT_OFS)) begin
            rdata_o = wcnt_q;
        end else begin
            for (int i = 0; i < NUM_SCR; i++) begin
                if (idx_i == 3'(i)) rdata_o = scr_q[i];
            end
        end
    end

endmodule

// File: rtl/icb_slv_test.sv
// ICB test slave: single-outstanding, registered response, one transaction
// per cycle when the master keeps rsp_ready high.
module icb_slv_test
    import icb_slv_test_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEF,
    parameter int          WIN_BITS = 12
) (
    input  logic        hfclk,
    input  logic        rst_n,
    input  logic        bus_rst_n,
    input  logic        i_icb_cmd_valid,
    output logic        i_icb_cmd_ready,
    input  logic [31:0] i_icb_cmd_addr,
    input  logic        i_icb_cmd_read,
    input  logic [31:0] i_icb_cmd_wdata,
    input  logic [3:0]  i_icb_cmd_wmask,
    output logic        i_icb_rsp_valid,
    input  logic        i_icb_rsp_ready,
    output logic [31:0] i_icb_rsp_rdata,
    output logic        i_icb_rsp_err
);

    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q,   rsp_err_d;
    logic                accept;
    logic                in_win;
    logic [WIN_BITS-1:0] win_ofs;
    logic [31:0]         reg_rdata;
    logic                unused_addr;

    assign win_ofs     = i_icb_cmd_addr[WIN_BITS-1:0];
    assign in_win      = (win_ofs >> 5) == '0;
    assign unused_addr = ^{i_icb_cmd_addr[31:WIN_BITS], i_icb_cmd_addr[1:0]};

    assign i_icb_cmd_ready = ~rsp_valid_q | i_icb_rsp_ready;
    assign accept          = i_icb_cmd_valid & i_icb_cmd_ready;

    icb_slv_test_regfile #(
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .hfclk     (hfclk),
        .rst_n     (rst_n),
        .bus_rst_n (bus_rst_n),
        .we_i      (accept & ~i_icb_cmd_read & in_win),
        .idx_i     (word_idx(i_icb_cmd_addr[4:0])),
        .wdata_i   (i_icb_cmd_wdata),
        .wmask_i   (i_icb_cmd_wmask),
        .rdata_o   (reg_rdata)
    );

    // Response next-state: load on accept (even while the old one retires),
    // clear on handshake, otherwise hold the pending response stable.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = ~in_win;
            rsp_rdata_d = (i_icb_cmd_read && in_win) ? reg_rdata : '0;
        end else if (i_icb_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response registers; soft reset wins over a same-cycle accept.
    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (!bus_rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign i_icb_rsp_valid = rsp_valid_q;
    assign i_icb_rsp_rdata = rsp_rdata_q;
    assign i_icb_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_icb_slv_test.sv
// Self-checking bench for icb_slv_test with a register-map reference model.
module tb_icb_slv_test;

    localparam logic [31:0] ID_EXP = 32'h4D56_5530;

    logic        hfclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic        cmd_read = 1'b0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wmask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_asrt = 0;
    int n_fail = 0;

    logic [31:0] m_scr [6];
    logic [31:0] m_wcnt;

    always #5 hfclk = ~hfclk;

    icb_slv_test dut (
        .hfclk           (hfclk),
        .rst_n           (rst_n),
        .bus_rst_n       (bus_rst_n),
        .i_icb_cmd_valid (cmd_valid),
        .i_icb_cmd_ready (cmd_ready),
        .i_icb_cmd_addr  (cmd_addr),
        .i_icb_cmd_read  (cmd_read),
        .i_icb_cmd_wdata (cmd_wdata),
        .i_icb_cmd_wmask (cmd_wmask),
        .i_icb_rsp_valid (rsp_valid),
        .i_icb_rsp_ready (rsp_ready),
        .i_icb_rsp_rdata (rsp_rdata),
        .i_icb_rsp_err   (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 6; i++) m_scr[i] = '0;
        m_wcnt = '0;
    endtask

    function automatic logic [31:0] mdl_read(input int idx);
        if (idx < 6) return m_scr[idx];
        if (idx == 6) return ID_EXP;
        return m_wcnt;
    endfunction

    // Applies one command to the model; returns the expected response.
    task automatic mdl_cmd(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] mask, output logic [31:0] exp_rd, output logic exp_err);
        int  idx;
        bit  inwin;
        idx   = int'((addr % 32) / 4);
        inwin = ((addr % 4096) / 32) == 0;
        exp_err = !inwin;
        exp_rd  = (rd && inwin) ? mdl_read(idx) : 32'd0;
        if (!rd && inwin) begin
            m_wcnt = m_wcnt + 1;
            if (idx < 6)
                for (int b = 0; b < 4; b++)
                    if (mask[b]) m_scr[idx][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    task automatic drive(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] mask);
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_wmask = mask;
    endtask

    // One complete transaction with rsp_ready held high, then an idle cycle.
    task automatic txn(input string tag, input bit rd, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] mask);
        logic [31:0] e_rd;
        logic        e_err;
        @(negedge hfclk);
        chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        drive(rd, addr, wd, mask);
        mdl_cmd(rd, addr, wd, mask, e_rd, e_err);
        @(posedge hfclk);
        #1;
        cmd_valid = 1'b0;
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rdata"}, rsp_rdata, e_rd);
        chk({tag, ".err"}, 32'(rsp_err), 32'(e_err));
        @(posedge hfclk);
        #1;
        chk({tag, ".retired"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] e_rd;
        logic        e_err;
        logic [31:0] r;
        bit          rd;
        int          widx;
        bit          oow;
        logic [31:0] addr;

        mdl_reset();

        // Reset state
        #1;
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.err", 32'(rsp_err), 32'd0);
        repeat (3) @(negedge hfclk);
        rst_n = 1'b1;
        txn("rd_scr0", 1'b1, 32'h00, '0, '0);
        txn("rd_id", 1'b1, 32'h18, '0, '0);
        txn("rd_wcnt", 1'b1, 32'h1C, '0, '0);

        // Byte mask
        txn("wr_scr1_full", 1'b0, 32'h04, 32'hDEAD_BEEF, 4'hF);
        txn("rd_scr1_full", 1'b1, 32'h04, '0, '0);
        txn("wr_scr1_mask", 1'b0, 32'h04, 32'h1122_3344, 4'b0101);
        txn("rd_scr1_mask", 1'b1, 32'h04, '0, '0);
        chk("mask.model", mdl_read(1), 32'hDE22_BE44);
        txn("rd_wcnt2", 1'b1, 32'h1C, '0, '0);
        txn("wr_nomask", 1'b0, 32'h0C, 32'hFFFF_FFFF, 4'h0);
        txn("rd_nomask", 1'b1, 32'h0C, '0, '0);

        // Back-to-back write then read of the same word
        @(negedge hfclk);
        drive(1'b0, 32'h08, 32'h55, 4'hF);
        mdl_cmd(1'b0, 32'h08, 32'h55, 4'hF, e_rd, e_err);
        @(posedge hfclk);
        #1;
        drive(1'b1, 32'h08, '0, '0);
        chk("b2b.wr_valid", 32'(rsp_valid), 32'd1);
        chk("b2b.wr_rdata", rsp_rdata, 32'd0);
        chk("b2b.cmd_ready", 32'(cmd_ready), 32'd1);
        mdl_cmd(1'b1, 32'h08, '0, '0, e_rd, e_err);
        @(posedge hfclk);
        #1;
        cmd_valid = 1'b0;
        chk("b2b.rd_valid", 32'(rsp_valid), 32'd1);
        chk("b2b.rd_rdata", rsp_rdata, 32'h55);
        chk("b2b.rd_err", 32'(rsp_err), 32'd0);
        @(posedge hfclk);
        #1;
        chk("b2b.retired", 32'(rsp_valid), 32'd0);

        // Response backpressure, with a second command waiting
        @(negedge hfclk);
        rsp_ready = 1'b0;
        drive(1'b1, 32'h18, '0, '0);
        @(posedge hfclk);
        #1;
        drive(1'b0, 32'h04, 32'hA5A5_A5A5, 4'hF);
        for (int c = 0; c < 5; c++) begin
            @(negedge hfclk);
            chk("bp.cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp.rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp.rdata", rsp_rdata, ID_EXP);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp.release_ready", 32'(cmd_ready), 32'd1);
        mdl_cmd(1'b0, 32'h04, 32'hA5A5_A5A5, 4'hF, e_rd, e_err);
        @(posedge hfclk);
        #1;
        cmd_valid = 1'b0;
        chk("bp.next_valid", 32'(rsp_valid), 32'd1);
        chk("bp.next_rdata", rsp_rdata, 32'd0);
        chk("bp.next_err", 32'(rsp_err), 32'd0);
        @(posedge hfclk);
        #1;
        chk("bp.retired", 32'(rsp_valid), 32'd0);
        txn("bp.rd_scr1", 1'b1, 32'h04, '0, '0);

        // Errors and read-only words
        txn("err_wr_40", 1'b0, 32'h40, 32'hFF, 4'hF);
        txn("err_rd_100", 1'b1, 32'h100, '0, '0);
        txn("err_wcnt", 1'b1, 32'h1C, '0, '0);
        txn("wr_id", 1'b0, 32'h18, 32'h0, 4'hF);
        txn("rd_id2", 1'b1, 32'h18, '0, '0);
        txn("rd_wcnt3", 1'b1, 32'h1C, '0, '0);
        txn("wr_wcnt", 1'b0, 32'h1C, 32'h0, 4'hF);
        txn("rd_wcnt4", 1'b1, 32'h1C, '0, '0);
        txn("hi_addr", 1'b1, 32'hFFFF_F004, '0, '0);

        // Randomized traffic against the model
        for (int k = 0; k < 60; k++) begin
            r    = $urandom();
            rd   = $urandom_range(0, 1) == 1;
            widx = $urandom_range(0, 7);
            oow  = $urandom_range(0, 5) == 0;
            addr = (r & 32'hFFFF_F003) | (32'(widx) << 2);
            if (oow) addr = addr | (32'($urandom_range(1, 127)) << 5);
            txn("rand", rd, addr, $urandom(), 4'($urandom_range(0, 15)));
        end

        // Async reset with a response pending
        txn("pre_rst_wr", 1'b0, 32'h08, 32'h1234_5678, 4'hF);
        @(negedge hfclk);
        rsp_ready = 1'b0;
        drive(1'b1, 32'h08, '0, '0);
        @(posedge hfclk);
        #1;
        cmd_valid = 1'b0;
        chk("arst.pending", 32'(rsp_valid), 32'd1);
        @(negedge hfclk);
        rst_n = 1'b0;
        #1;
        chk("arst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst.cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge hfclk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        mdl_reset();
        for (int i = 0; i < 6; i++) txn("arst.scr", 1'b1, 32'(i * 4), '0, '0);

        // Synchronous soft reset: pending response dropped, same-cycle accept ignored
        txn("pre_srst_wr", 1'b0, 32'h0C, 32'hCAFE_F00D, 4'hF);
        @(negedge hfclk);
        rsp_ready = 1'b0;
        drive(1'b1, 32'h0C, '0, '0);
        @(posedge hfclk);
        #1;
        cmd_valid = 1'b0;
        @(negedge hfclk);
        bus_rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 32'h10, 32'hFFFF_FFFF, 4'hF);
        #1;
        chk("srst.before_edge", 32'(rsp_valid), 32'd1);
        @(posedge hfclk);
        #1;
        cmd_valid = 1'b0;
        chk("srst.rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge hfclk);
        bus_rst_n = 1'b1;
        mdl_reset();
        #1;
        chk("srst.idle", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 6; i++) txn("srst.scr", 1'b1, 32'(i * 4), '0, '0);
        txn("srst.wcnt", 1'b1, 32'h1C, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
